// File: rtl/ysyx_22040383_ifu_pkg.sv
// Shared IFU constants, FSM state encoding and helpers.
// Imported by the fetch unit and its output buffer.
package ysyx_22040383_ifu_pkg;

  localparam int IFU_XLEN = 64;

  localparam logic [IFU_XLEN-1:0] IFU_RESET_PC =
    64'h0000_0000_8000_0000;

  localparam logic [31:0] BUBBLE_INST = 32'h0;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_TRAP = 2'd3
  } ifu_state_e;

  function automatic logic misaligned(
    input logic [1:0] lsb
  );
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22040383_ifu_outbuf.sv
// IF->ID output slot: {pc, pc+4, inst} plus valid.
// Ports: clk/rst_n, load + data, clear; zero-muxed slot outputs.
module ysyx_22040383_ifu_outbuf
  import ysyx_22040383_ifu_pkg::*;
#(
  parameter int XLEN = IFU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] ld_pc,
  input  logic [XLEN-1:0] ld_pc4,
  input  logic [31:0]     ld_inst,
  output logic            valid,
  output logic [XLEN-1:0] now_pc,
  output logic [XLEN-1:0] pc_plus_4,
  output logic [31:0]     instruction
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc4_q;
  logic [31:0]     inst_q;
  logic            valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      pc4_q   <= '0;
      inst_q  <= BUBBLE_INST;
      valid_q <= 1'b0;
    end else begin
      unique case (1'b1)
        clear: valid_q <= 1'b0;
        load: begin
          pc_q    <= ld_pc;
          pc4_q   <= ld_pc4;
          inst_q  <= ld_inst;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // No valid bit crosses to ID: empty slot reads as zeros.
  assign valid       = valid_q;
  assign now_pc      = valid_q ? pc_q   : '0;
  assign pc_plus_4   = valid_q ? pc4_q  : '0;
  assign instruction = valid_q ? inst_q : BUBBLE_INST;

endmodule

// File: rtl/ysyx_22040383_ifu.sv
// Instruction fetch unit: PC, one-outstanding fetch FSM, IF/ID slot.
// Optional YSYX_22040383_IFU_MISALIGN_EN adds if_exc_misalign + S_TRAP.
module ysyx_22040383_ifu
  import ysyx_22040383_ifu_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            stall_id_reg,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_data,
`ifdef YSYX_22040383_IFU_MISALIGN_EN
  output logic            if_exc_misalign,
`endif
  output logic [XLEN-1:0] if_idpr_now_pc,
  output logic [XLEN-1:0] if_idpr_pc_plus_4,
  output logic [31:0]     if_idpr_instruction
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  ifu_state_e      state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] pc4;
  logic            discard, discard_n;
  logic            req_fire;
  logic            pending;
  logic            bad_tgt;
  logic [XLEN-1:0] tgt;
  logic            ob_load, ob_clear;
  logic            ob_valid;

`ifdef YSYX_22040383_IFU_MISALIGN_EN
  logic            mis, mis_n;
  assign tgt     = redirect_pc;
  assign bad_tgt = misaligned(redirect_pc[1:0]);
`else
  assign tgt     = redirect_pc & ALIGN_MASK;
  assign bad_tgt = 1'b0;
`endif

  assign pc4 = pc + XLEN'(4);

  // Gated by reset so nothing is requested while held in reset.
  assign ifu_req_valid = (state == S_REQ) & sys_rst_n;
  assign ifu_req_addr  = pc;
  assign req_fire      = ifu_req_valid & ifu_req_ready;

  // A response still owed by the bus after this cycle.
  always_comb begin
    pending = 1'b0;
    unique case (state)
      S_REQ:   pending = req_fire;
      S_WAIT:  pending = ~ifu_rsp_valid;
      S_TRAP:  pending = discard & ~ifu_rsp_valid;
      default: pending = 1'b0;
    endcase
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard;
    ob_load   = 1'b0;
    ob_clear  = 1'b0;
`ifdef YSYX_22040383_IFU_MISALIGN_EN
    mis_n     = mis;
`endif
    if (redirect_valid) begin
      ob_clear  = 1'b1;
      pc_n      = tgt;
      discard_n = pending;
      // An owed response must drain before a new request.
      state_n   = pending ? S_WAIT : S_REQ;
`ifdef YSYX_22040383_IFU_MISALIGN_EN
      mis_n     = bad_tgt;
      if (bad_tgt) state_n = S_TRAP;
`endif
    end else begin
      unique case (state)
        S_REQ: begin
          if (req_fire) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (ifu_rsp_valid) begin
            if (discard) begin
              discard_n = 1'b0;
              state_n   = S_REQ;
            end else begin
              ob_load = 1'b1;
              pc_n    = pc4;
              state_n = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_id_reg) begin
            ob_clear = 1'b1;
            state_n  = S_REQ;
          end
        end
        S_TRAP: begin
          if (ifu_rsp_valid) discard_n = 1'b0;
        end
        default: state_n = S_REQ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      discard <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      discard <= discard_n;
    end
  end

`ifdef YSYX_22040383_IFU_MISALIGN_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) mis <= 1'b0;
    else            mis <= mis_n;
  end

  assign if_exc_misalign = mis;
`endif

  ysyx_22040383_ifu_outbuf #(
    .XLEN(XLEN)
  ) u_outbuf (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .load        (ob_load),
    .clear       (ob_clear),
    .ld_pc       (pc),
    .ld_pc4      (pc4),
    .ld_inst     (ifu_rsp_data),
    .valid       (ob_valid),
    .now_pc      (if_idpr_now_pc),
    .pc_plus_4   (if_idpr_pc_plus_4),
    .instruction (if_idpr_instruction)
  );

  logic unused_ok;
  assign unused_ok = ob_valid ^ bad_tgt;

endmodule

// File: tb/tb_ysyx_22040383_ifu.sv
// Directed self-checking bench for the fetch unit.
// Inputs change at negedge; outputs sampled at negedge.
module tb_ysyx_22040383_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        rd_v;
  logic [63:0] rd_pc;
  logic        req_v;
  logic        req_rdy;
  logic [63:0] req_addr;
  logic        rsp_v;
  logic [31:0] rsp_d;
  logic [63:0] o_pc;
  logic [63:0] o_pc4;
  logic [31:0] o_inst;
`ifdef YSYX_22040383_IFU_MISALIGN_EN
  logic        mis;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_22040383_ifu dut (
    .sys_clk            (clk),
    .sys_rst_n          (rst_n),
    .stall_id_reg       (stall),
    .redirect_valid     (rd_v),
    .redirect_pc        (rd_pc),
    .ifu_req_valid      (req_v),
    .ifu_req_ready      (req_rdy),
    .ifu_req_addr       (req_addr),
    .ifu_rsp_valid      (rsp_v),
    .ifu_rsp_data       (rsp_d),
`ifdef YSYX_22040383_IFU_MISALIGN_EN
    .if_exc_misalign    (mis),
`endif
    .if_idpr_now_pc     (o_pc),
    .if_idpr_pc_plus_4  (o_pc4),
    .if_idpr_instruction(o_inst)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_slot(
    input string       tag,
    input logic [63:0] pc,
    input logic [63:0] pc4,
    input logic [31:0] inst
  );
    chk({tag, ".pc"},   o_pc,   pc);
    chk({tag, ".pc4"},  o_pc4,  pc4);
    chk({tag, ".inst"}, {32'h0, o_inst}, {32'h0, inst});
  endtask

  task automatic chk_req(
    input string       tag,
    input logic        v,
    input logic [63:0] a
  );
    chk({tag, ".rv"}, {63'h0, req_v}, {63'h0, v});
    if (v) chk({tag, ".ra"}, req_addr, a);
  endtask

  initial begin
    rst_n   = 1'b0;
    stall   = 1'b0;
    rd_v    = 1'b0;
    rd_pc   = '0;
    req_rdy = 1'b0;
    rsp_v   = 1'b0;
    rsp_d   = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk_req("rst", 1'b0, 64'h0);
    chk_slot("rst", 64'h0, 64'h0, 32'h0);

    // 1: first fetch
    rst_n   = 1'b1;
    req_rdy = 1'b1;
    #1 chk_req("t1.req", 1'b1, 64'h8000_0000);
    @(negedge clk);
    chk_req("t1.wait", 1'b0, 64'h0);
    req_rdy = 1'b0;
    rsp_v   = 1'b1;
    rsp_d   = 32'h0000_0013;
    @(negedge clk);
    rsp_v = 1'b0;
    chk_slot("t1.out", 64'h8000_0000, 64'h8000_0004, 32'h13);
    stall = 1'b1;

    // 2: stall in S_HOLD
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_slot("t2.hold", 64'h8000_0000, 64'h8000_0004, 32'h13);
      chk_req("t2.hold", 1'b0, 64'h0);
    end
    stall = 1'b0;
    @(negedge clk);
    chk_req("t2.rel", 1'b1, 64'h8000_0004);
    chk_slot("t2.rel", 64'h0, 64'h0, 32'h0);
    req_rdy = 1'b1;

    // 3: redirect during S_WAIT, late response dropped
    @(negedge clk);
    req_rdy = 1'b0;
    rd_v    = 1'b1;
    rd_pc   = 64'h8000_0100;
    @(negedge clk);
    rd_v = 1'b0;
    chk_req("t3.w1", 1'b0, 64'h0);
    @(negedge clk);
    chk_req("t3.w2", 1'b0, 64'h0);
    rsp_v = 1'b1;
    rsp_d = 32'hDEAD_BEEF;
    @(negedge clk);
    rsp_v = 1'b0;
    chk_slot("t3.drop", 64'h0, 64'h0, 32'h0);
    chk_req("t3.req", 1'b1, 64'h8000_0100);
    req_rdy = 1'b1;

    // 4: redirect coincident with response
    @(negedge clk);
    req_rdy = 1'b0;
    rsp_v   = 1'b1;
    rsp_d   = 32'h1234_5678;
    rd_v    = 1'b1;
    rd_pc   = 64'h8000_0180;
    @(negedge clk);
    rsp_v = 1'b0;
    rd_v  = 1'b0;
    chk_slot("t4.drop", 64'h0, 64'h0, 32'h0);
    chk_req("t4.req", 1'b1, 64'h8000_0180);

    // 5: pc wrap
    rd_v  = 1'b1;
    rd_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    rd_v = 1'b0;
    chk_req("t5.req", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    req_rdy = 1'b1;
    @(negedge clk);
    req_rdy = 1'b0;
    rsp_v   = 1'b1;
    rsp_d   = 32'h0010_0093;
    @(negedge clk);
    rsp_v = 1'b0;
    chk_slot("t5.out", 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h0010_0093);
    @(negedge clk);
    chk_req("t5.wrap", 1'b1, 64'h0);

    // 6: misaligned redirect
    rd_v  = 1'b1;
    rd_pc = 64'h8000_0102;
    @(negedge clk);
    rd_v = 1'b0;
`ifdef YSYX_22040383_IFU_MISALIGN_EN
    chk("t6.mis", {63'h0, mis}, 64'h1);
    chk_req("t6.trap", 1'b0, 64'h0);
    @(negedge clk);
    chk("t6.stick", {63'h0, mis}, 64'h1);
    chk_req("t6.trap2", 1'b0, 64'h0);
    chk_slot("t6.bub", 64'h0, 64'h0, 32'h0);
    rd_v  = 1'b1;
    rd_pc = 64'h8000_0200;
    @(negedge clk);
    rd_v = 1'b0;
    chk("t6.clr", {63'h0, mis}, 64'h0);
    chk_req("t6.req", 1'b1, 64'h8000_0200);
`else
    chk_req("t6.align", 1'b1, 64'h8000_0100);
`endif

    // 7: redirect while request accepted same cycle
    req_rdy = 1'b1;
    rd_v    = 1'b1;
    rd_pc   = 64'h8000_0300;
    @(negedge clk);
    req_rdy = 1'b0;
    rd_v    = 1'b0;
    chk_req("t7.wait", 1'b0, 64'h0);
    rsp_v = 1'b1;
    rsp_d = 32'hAAAA_AAAA;
    @(negedge clk);
    rsp_v = 1'b0;
    chk_slot("t7.drop", 64'h0, 64'h0, 32'h0);
    chk_req("t7.req", 1'b1, 64'h8000_0300);

    // 8: reset mid-transaction, late response ignored
    req_rdy = 1'b1;
    @(negedge clk);
    req_rdy = 1'b0;
    rst_n   = 1'b0;
    #1 chk_req("t8.rst", 1'b0, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_v = 1'b1;
    rsp_d = 32'h5555_5555;
    #1 chk_req("t8.rel", 1'b1, 64'h8000_0000);
    @(negedge clk);
    rsp_v = 1'b0;
    chk_slot("t8.ign", 64'h0, 64'h0, 32'h0);
    chk_req("t8.req", 1'b1, 64'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
